alu_seq_ctrl: RTL and testbench

Multicycle control sequencer for the CPU datapath: owns the select lines of the ALU operand multiplexers (source A, source B) and the ALU operation code, and steps each instruction through fetch, decode, execute, memory and write-back. It sits between the instruction register and the datapath. It uses a ready handshake with the memory interface, so variable-latency memory stalls the sequence instead of corrupting it.

---
 rtl/alu_seq_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping with a memory ready handshake.
// Define ALU_SEQ_RETIRE_CNT_EN to add the retire_cnt instruction-retire counter output.
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic [1:0]  flagAluSrcA,
    output logic [1:0]  flagAluSrcB,
    output logic [2:0]  aluOp,
    output logic        mem_req,
    output logic        mem_wr,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src_jump,
    output logic        reg_write,
    output logic        halted,
`ifdef ALU_SEQ_RETIRE_CNT_EN
    output logic [31:0] retire_cnt,
`endif
    output logic        opcode_err
);

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_WAIT = 4'd6,
        ST_WB       = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_ERR      = 4'd10,
        ST_HALT     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_HALT  = 6'h0D;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;

    function automatic logic [2:0] rTypeAluOp(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLL:  op = ALU_SLL;
            default: op = ALU_PASS;
        endcase
        return op;
    endfunction

    state_t     stateR, nextStateS;
    logic [1:0] srcAR, srcAS, srcBR, srcBS;
    logic [2:0] aluOpR, aluOpS;
    logic       memReqR, memReqS, memWrR, memWrS;
    logic       fetchR, fetchS, branchR, branchS, jumpR, jumpS;
    logic       regWriteR, regWriteS, haltedR, haltedS, errR, errS;
    logic       fetchReadyS;

    // Next-state selection from the current state, decoded instruction and handshake inputs.
    always_comb begin
        nextStateS = stateR;
        case (stateR)
            ST_RESET:  nextStateS = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) nextStateS = ST_DECODE;
                else           nextStateS = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLL: nextStateS = ST_EXEC_R;
                            FN_HALT: nextStateS = ST_HALT;
                            default: nextStateS = ST_ERR;
                        endcase
                    end
                    OP_ADDI:      nextStateS = ST_EXEC_I;
                    OP_LW, OP_SW: nextStateS = ST_MEM_ADDR;
                    OP_BEQ:       nextStateS = ST_BRANCH;
                    OP_J:         nextStateS = ST_JUMP;
                    default:      nextStateS = ST_ERR;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: nextStateS = ST_WB;
            ST_MEM_ADDR:          nextStateS = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (mem_ready) nextStateS = memWrR ? ST_FETCH : ST_WB;
                else           nextStateS = ST_MEM_WAIT;
            end
            ST_WB, ST_BRANCH, ST_JUMP, ST_ERR: nextStateS = ST_FETCH;
            ST_HALT:  nextStateS = ST_HALT;
            default:  nextStateS = ST_RESET;
        endcase
    end

    // Output decode of the state being entered, so the registered outputs line up with it.
    always_comb begin
        srcAS     = 2'b00;
        srcBS     = 2'b00;
        aluOpS    = ALU_PASS;
        memReqS   = 1'b0;
        memWrS    = 1'b0;
        fetchS    = 1'b0;
        branchS   = 1'b0;
        jumpS     = 1'b0;
        regWriteS = 1'b0;
        haltedS   = 1'b0;
        errS      = 1'b0;
        case (nextStateS)
            ST_FETCH: begin
                memReqS = 1'b1;
                fetchS  = 1'b1;
            end
            ST_DECODE: begin
                srcBS  = 2'b11;
                aluOpS = ALU_ADD;
            end
            ST_EXEC_R: begin
                srcAS  = (funct == FN_SLL) ? 2'b10 : 2'b01;
                aluOpS = rTypeAluOp(funct);
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                srcAS  = 2'b01;
                srcBS  = 2'b10;
                aluOpS = ALU_ADD;
            end
            ST_MEM_WAIT: begin
                memReqS = 1'b1;
                // Direction is latched on entry so it cannot move during a stall.
                memWrS  = (stateR == ST_MEM_WAIT) ? memWrR : (opcode == OP_SW);
            end
            ST_WB:     regWriteS = 1'b1;
            ST_BRANCH: begin
                srcAS   = 2'b01;
                aluOpS  = ALU_SUB;
                branchS = 1'b1;
            end
            ST_JUMP:   jumpS   = 1'b1;
            ST_ERR:    errS    = 1'b1;
            ST_HALT:   haltedS = 1'b1;
            default:   srcAS   = 2'b00;
        endcase
    end

    // State and output registers; reset low clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateR    <= ST_RESET;
            srcAR     <= 2'b00;
            srcBR     <= 2'b00;
            aluOpR    <= ALU_PASS;
            memReqR   <= 1'b0;
            memWrR    <= 1'b0;
            fetchR    <= 1'b0;
            branchR   <= 1'b0;
            jumpR     <= 1'b0;
            regWriteR <= 1'b0;
            haltedR   <= 1'b0;
            errR      <= 1'b0;
        end else begin
            stateR    <= nextStateS;
            srcAR     <= srcAS;
            srcBR     <= srcBS;
            aluOpR    <= aluOpS;
            memReqR   <= memReqS;
            memWrR    <= memWrS;
            fetchR    <= fetchS;
            branchR   <= branchS;
            jumpR     <= jumpS;
            regWriteR <= regWriteS;
            haltedR   <= haltedS;
            errR      <= errS;
        end
    end

    // PC+4 strobes exist only on the cycle memory returns the instruction word.
    assign fetchReadyS = fetchR & mem_ready;
    assign flagAluSrcA = srcAR;
    assign flagAluSrcB = fetchReadyS ? 2'b01 : srcBR;
    assign aluOp       = fetchReadyS ? ALU_ADD : aluOpR;
    assign mem_req     = memReqR;
    assign mem_wr      = memWrR;
    assign ir_write    = fetchReadyS;
    assign pc_write    = fetchReadyS | (branchR & alu_zero) | jumpR;
    assign pc_src_jump = jumpR;
    assign reg_write   = regWriteR;
    assign halted      = haltedR;
    assign opcode_err  = errR;

`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [31:0] retireCntR;
    logic        retireS;

    assign retireS = (nextStateS == ST_FETCH) &&
                     (stateR inside {ST_WB, ST_MEM_WAIT, ST_BRANCH, ST_JUMP, ST_ERR});

    // Retired-instruction counter; wraps naturally and cannot move while halted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retireCntR <= 32'd0;
        end else if (retireS) begin
            retireCntR <= retireCntR + 32'd1;
        end
    end

    assign retire_cnt = retireCntR;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed vector table, random instruction stream
// against a per-instruction phase model, and reset/halt corner sequences.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        alu_zero, mem_ready;
    logic [1:0]  flagAluSrcA, flagAluSrcB;
    logic [2:0]  aluOp;
    logic        mem_req, mem_wr, ir_write, pc_write, pc_src_jump, reg_write, halted, opcode_err;
`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int passCnt = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .flagAluSrcA(flagAluSrcA), .flagAluSrcB(flagAluSrcB), .aluOp(aluOp),
        .mem_req(mem_req), .mem_wr(mem_wr), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src_jump(pc_src_jump), .reg_write(reg_write), .halted(halted),
`ifdef ALU_SEQ_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .opcode_err(opcode_err)
    );

    // Packed view: {srcA, srcB, aluOp, req, wr, irw, pcw, pcj, regw, halted, err}
    logic [14:0] act;
    assign act = {flagAluSrcA, flagAluSrcB, aluOp, mem_req, mem_wr, ir_write,
                  pc_write, pc_src_jump, reg_write, halted, opcode_err};

    function automatic logic [14:0] o(input logic [1:0] a, input logic [1:0] b, input logic [2:0] op,
                                      input logic req, input logic wr, input logic irw, input logic pcw,
                                      input logic pcj, input logic rw, input logic hl, input logic er);
        return {a, b, op, req, wr, irw, pcw, pcj, rw, hl, er};
    endfunction

    function automatic logic [14:0] sel(input logic [1:0] a, input logic [1:0] b, input logic [2:0] op);
        return o(a, b, op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    logic [14:0] fetchRdy, fetchWait, decodeExp, haltExp, errExp, jumpExp;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // One clock cycle: drive this cycle's inputs after the edge, observe mid-cycle.
    task automatic step(input logic rdy, input logic zr);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        alu_zero  = zr;
        @(negedge clk);
        check("srcA_never_11", {31'd0, flagAluSrcA != 2'b11}, 32'd1);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        int          stall;
        logic        zr;
        int          cyc;
        logic [14:0] exec;
        logic        wb;
    } vec_t;
    vec_t vt[14];

    typedef struct packed {
        logic        rdy;
        logic        zr;
        logic [14:0] exp;
    } cyc_t;
    cyc_t mq[$];

    function automatic logic [2:0] specAluOp(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b001;
            6'h22:   return 3'b010;
            6'h24:   return 3'b011;
            6'h25:   return 3'b100;
            6'h00:   return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Run one table vector; entry precondition: fetch-with-ready already observed.
    task automatic runVec(input int i);
        logic memOp, rdy, done;
        int cycles;
        memOp  = (vt[i].op == 6'h23) || (vt[i].op == 6'h2B);
        opcode = vt[i].op;
        funct  = vt[i].fn;
        done   = 1'b0;
        cycles = 0;
        for (int c = 2; c <= 30 && !done; c++) begin
            rdy = 1'b1;
            if (memOp && c >= 4 && c < 4 + vt[i].stall) rdy = 1'b0;
            step(rdy, vt[i].zr);
            if (c == 3) check($sformatf("exec_v%0d", i), {17'd0, act}, {17'd0, vt[i].exec});
            if (memOp && c >= 4 && c <= 4 + vt[i].stall) begin
                check($sformatf("memreq_hold_v%0d", i), {31'd0, mem_req}, 32'd1);
                check($sformatf("memwr_hold_v%0d", i), {31'd0, mem_wr}, {31'd0, vt[i].op == 6'h2B});
            end
            if (c == vt[i].cyc) check($sformatf("regwrite_last_v%0d", i), {31'd0, reg_write}, {31'd0, vt[i].wb});
            if (ir_write) begin
                done   = 1'b1;
                cycles = c - 1;
                check($sformatf("refetch_v%0d", i), {17'd0, act}, {17'd0, fetchRdy});
            end
        end
        check($sformatf("cycles_v%0d", i), cycles, vt[i].cyc);
    endtask

    // Reference model: list the phases an instruction passes through, ending at the next fetch.
    task automatic runModel(input logic [5:0] op, input logic [5:0] fn, input int idx);
        logic z;
        logic isSw;
        int w;
        mq.delete();
        mq.push_back({rb(), rb(), decodeExp});
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h00)) begin
            mq.push_back({rb(), rb(), sel((fn == 6'h00) ? 2'b10 : 2'b01, 2'b00, specAluOp(fn))});
            mq.push_back({rb(), rb(), o(2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)});
        end else if (op == 6'h08) begin
            mq.push_back({rb(), rb(), sel(2'b01, 2'b10, 3'b001)});
            mq.push_back({rb(), rb(), o(2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)});
        end else if (op == 6'h23 || op == 6'h2B) begin
            isSw = (op == 6'h2B);
            mq.push_back({rb(), rb(), sel(2'b01, 2'b10, 3'b001)});
            w = $urandom_range(0, 3);
            for (int k = 0; k < w; k++)
                mq.push_back({1'b0, rb(), o(2'b00, 2'b00, 3'b000, 1'b1, isSw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
            mq.push_back({1'b1, rb(), o(2'b00, 2'b00, 3'b000, 1'b1, isSw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
            if (!isSw)
                mq.push_back({rb(), rb(), o(2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)});
        end else if (op == 6'h04) begin
            z = rb();
            mq.push_back({rb(), z, o(2'b01, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, z, 1'b0, 1'b0, 1'b0, 1'b0)});
        end else if (op == 6'h02) begin
            mq.push_back({rb(), rb(), jumpExp});
        end else begin
            mq.push_back({rb(), rb(), errExp});
        end
        w = $urandom_range(0, 2);
        for (int k = 0; k < w; k++) mq.push_back({1'b0, rb(), fetchWait});
        mq.push_back({1'b1, rb(), fetchRdy});

        opcode = op;
        funct  = fn;
        foreach (mq[k]) begin
            step(mq[k].rdy, mq[k].zr);
            check($sformatf("model_i%0d_c%0d_op%h_fn%h", idx, k, op, fn), {17'd0, act}, {17'd0, mq[k].exp});
        end
    endtask

    // Bound on total run time so a stuck sequence still ends with a report.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] rop, rfn;
        fetchRdy  = o(2'b00, 2'b01, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        fetchWait = o(2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        decodeExp = sel(2'b00, 2'b11, 3'b001);
        haltExp   = o(2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        errExp    = o(2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        jumpExp   = o(2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        vt[0]  = '{6'h00, 6'h20, 0, 1'b0, 4, sel(2'b01, 2'b00, 3'b001), 1'b1};
        vt[1]  = '{6'h00, 6'h22, 0, 1'b0, 4, sel(2'b01, 2'b00, 3'b010), 1'b1};
        vt[2]  = '{6'h00, 6'h24, 0, 1'b0, 4, sel(2'b01, 2'b00, 3'b011), 1'b1};
        vt[3]  = '{6'h00, 6'h25, 0, 1'b0, 4, sel(2'b01, 2'b00, 3'b100), 1'b1};
        vt[4]  = '{6'h00, 6'h00, 0, 1'b0, 4, sel(2'b10, 2'b00, 3'b101), 1'b1};
        vt[5]  = '{6'h08, 6'h11, 0, 1'b0, 4, sel(2'b01, 2'b10, 3'b001), 1'b1};
        vt[6]  = '{6'h23, 6'h00, 3, 1'b0, 8, sel(2'b01, 2'b10, 3'b001), 1'b1};
        vt[7]  = '{6'h23, 6'h00, 0, 1'b0, 5, sel(2'b01, 2'b10, 3'b001), 1'b1};
        vt[8]  = '{6'h2B, 6'h00, 2, 1'b0, 6, sel(2'b01, 2'b10, 3'b001), 1'b0};
        vt[9]  = '{6'h04, 6'h00, 0, 1'b1, 3, o(2'b01, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0};
        vt[10] = '{6'h04, 6'h00, 0, 1'b0, 3, sel(2'b01, 2'b00, 3'b010), 1'b0};
        vt[11] = '{6'h02, 6'h00, 0, 1'b0, 3, jumpExp, 1'b0};
        vt[12] = '{6'h3F, 6'h00, 0, 1'b0, 3, errExp, 1'b0};
        vt[13] = '{6'h00, 6'h3F, 0, 1'b0, 3, errExp, 1'b0};

        reset = 1'b0; opcode = 6'h00; funct = 6'h00; alu_zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {17'd0, act}, 32'd0);
        reset = 1'b1;
        #1;
        check("reset_state_after_release", {17'd0, act}, 32'd0);
        step(1'b1, 1'b0);
        check("first_fetch", {17'd0, act}, {17'd0, fetchRdy});

        for (int i = 0; i < 14; i++) begin
            runVec(i);
`ifdef ALU_SEQ_RETIRE_CNT_EN
            if (i == 9) check("retire_cnt_10", retire_cnt, 32'd10);
`endif
        end

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 11))
                0:  begin rop = 6'h00; rfn = 6'h20; end
                1:  begin rop = 6'h00; rfn = 6'h22; end
                2:  begin rop = 6'h00; rfn = 6'h24; end
                3:  begin rop = 6'h00; rfn = 6'h25; end
                4:  begin rop = 6'h00; rfn = 6'h00; end
                5:  begin rop = 6'h08; rfn = 6'($urandom); end
                6:  begin rop = 6'h23; rfn = 6'($urandom); end
                7:  begin rop = 6'h2B; rfn = 6'($urandom); end
                8:  begin rop = 6'h04; rfn = 6'($urandom); end
                9:  begin rop = 6'h02; rfn = 6'($urandom); end
                10: begin rop = 6'($urandom); rfn = 6'($urandom); end
                default: begin rop = 6'h00; rfn = 6'($urandom); end
            endcase
            if (rop == 6'h00 && rfn == 6'h0D) rfn = 6'h01;
            runModel(rop, rfn, n);
        end

        // Reset during a stalled load abandons the request at once.
        opcode = 6'h23; funct = 6'h00;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("midwait_req", {31'd0, mem_req}, 32'd1);
        step(1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midwait_reset_async", {17'd0, act}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b0);
        check("fetch_after_midwait_reset", {17'd0, act}, {17'd0, fetchRdy});

        // Halt is terminal until reset, whatever the inputs do.
        opcode = 6'h00; funct = 6'h0D;
        step(1'b1, 1'b0);
        check("halt_decode", {17'd0, act}, {17'd0, decodeExp});
        for (int k = 0; k < 100; k++) begin
            step(rb(), rb());
            check($sformatf("halt_hold_%0d", k), {17'd0, act}, {17'd0, haltExp});
        end
        #2 reset = 1'b0;
        #1;
        check("halt_cleared_async", {31'd0, halted}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b0);
        check("fetch_after_halt", {17'd0, act}, {17'd0, fetchRdy});

`ifdef ALU_SEQ_RETIRE_CNT_EN
        check("retire_cnt_after_reset", retire_cnt, 32'd0);
        force dut.retireCntR = 32'hFFFF_FFFF;
        #1;
        release dut.retireCntR;
        opcode = 6'h02; funct = 6'h00;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("retire_cnt_wrap", retire_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
